// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor controller.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ssub_state_t;

  function automatic int ssub_cnt_w(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sub_bit_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bw_in, bw_out is the borrow.
module sub_bit_cell (
  input  logic x,
  input  logic y,
  input  logic bw_in,
  output logic d,
  output logic bw_out
);

  assign d      = x ^ y ^ bw_in;
  assign bw_out = (~x & y) | (~(x ^ y) & bw_in);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: a - b - bin, one bit per cycle LSB first, valid/ready on both sides.
// Optional borrow_in port enabled by defining SERIAL_SUB_BORROW_IN_EN.
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BORROW_IN_EN
  input  logic             borrow_in,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and a/b are only sampled on that edge.

  localparam int CW = ssub_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  ssub_state_t      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
  logic             bw_q, bw_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;

  logic             bin;
  logic             cell_d;
  logic             cell_bw;
  logic [WIDTH-1:0] diff_shifted;
  logic             diff_sr_lsb_unused;

`ifdef SERIAL_SUB_BORROW_IN_EN
  assign bin = borrow_in;
`else
  assign bin = 1'b0;
`endif

  sub_bit_cell u_cell (
    .x      (a_sr_q[0]),
    .y      (b_sr_q[0]),
    .bw_in  (bw_q),
    .d      (cell_d),
    .bw_out (cell_bw)
  );

  // The oldest bit falls off the bottom; after WIDTH shifts the register holds the full result.
  assign diff_shifted       = {cell_d, diff_sr_q[WIDTH-1:1]};
  assign diff_sr_lsb_unused = diff_sr_q[0];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    diff_sr_d    = diff_sr_q;
    bw_d         = bw_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_sr_d     = a;
          b_sr_d     = b;
          bw_d       = bin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        diff_sr_d = diff_shifted;
        a_sr_d    = a_sr_q >> 1;
        b_sr_d    = b_sr_q >> 1;
        bw_d      = cell_bw;
        if (cnt_q == LAST_BIT) begin
          diff_d       = diff_shifted;
          borrow_out_d = cell_bw;
          out_valid_d  = 1'b1;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      diff_sr_q    <= '0;
      bw_q         <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      diff_sr_q    <= diff_sr_d;
      bw_q         <= bw_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl (WIDTH=8); honours SERIAL_SUB_BORROW_IN_EN.
module tb_serial_subtractor_ctrl;

  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin_drv = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic         borrow_out;
  logic [W-1:0] diff;

  int checks = 0;
  int failures = 0;

  logic [W:0] exp_q[$];

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
`ifdef SERIAL_SUB_BORROW_IN_EN
    .borrow_in  (bin_drv),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: an accepted pair yields its result WIDTH edges later,
  // held until the consumer takes it.
  bit           m_live = 1'b0;
  int           m_left = 0;
  bit           m_valid = 1'b0;
  logic [W-1:0] m_diff = '0;
  bit           m_borrow = 1'b0;
  logic [W-1:0] p_diff = '0;
  bit           p_borrow = 1'b0;
  int           m_bin;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_live   = 1'b1;
      m_left   = 0;
      m_valid  = 1'b0;
      m_diff   = '0;
      m_borrow = 1'b0;
    end else if (m_live) begin
      if (m_valid) begin
        if (out_ready) m_valid = 1'b0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_valid  = 1'b1;
          m_diff   = p_diff;
          m_borrow = p_borrow;
        end
      end else if (in_valid) begin
`ifdef SERIAL_SUB_BORROW_IN_EN
        m_bin = int'(bin_drv);
`else
        m_bin = 0;
`endif
        p_borrow = (int'(a) < int'(b) + m_bin);
        p_diff   = W'(int'(a) - int'(b) - m_bin);
        m_left   = W;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("cyc_in_ready", in_ready, (!m_valid && m_left == 0));
      check("cyc_out_valid", out_valid, m_valid);
      check("cyc_diff", diff, m_diff);
      check("cyc_borrow", borrow_out, m_borrow);
    end
  end

  // driver
  task automatic wait_in_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", in_ready, 1);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                        input logic [W-1:0] ed, input logic eb, input int stall,
                        input bit keep_ready, input bit spam);
    int n;
    logic [W:0] expv;
    exp_q.push_back({eb, ed});
    wait_in_ready();
    a = ta; b = tb_v; bin_drv = tbin; in_valid = 1'b1; out_ready = keep_ready;
    @(posedge clk); #1;
    if (spam) begin
      a = 8'hAA; b = 8'h00; bin_drv = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    check("in_ready_run", in_ready, 0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, W);
    in_valid = 1'b0;
    expv = exp_q.pop_front();
    check("res_diff", diff, expv[W-1:0]);
    check("res_borrow", borrow_out, expv[W]);
    if (!keep_ready) begin
      repeat (stall) begin
        @(posedge clk); #1;
        check("hold_valid", out_valid, 1);
        check("hold_diff", diff, ed);
        check("hold_borrow", borrow_out, eb);
        check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow_out, 0);

    run_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 0, 1'b1, 1'b0);
    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 0, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    run_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 5, 1'b0, 1'b0);
    run_op(8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 2, 1'b0, 1'b1);
    run_op(8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1, 1'b0, 1'b0);

    // abort an operation when its bit counter sits at 3
    wait_in_ready();
    a = 8'h50; b = 8'h20; bin_drv = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_diff", diff, 0);
    check("abort_borrow", borrow_out, 0);
    run_op(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 0, 1'b0, 1'b0);

`ifdef SERIAL_SUB_BORROW_IN_EN
    run_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1, 1'b0, 1'b0);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
